sfx_scheduler: RTL and testbench

//  Shares the single Voice tone path between four sound-effect requesters (step, hit, win, lose).

---
 rtl/sfx_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_sfx_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// ----------------------------------------------------------------------------
// sfx_scheduler
//
// Shares the single Voice tone path between four sound-effect requesters
// (step, hit, win, lose). A fixed-priority arbiter with preemption picks the
// effect to play, and the effect is replayed as a note/duration sequence from
// a small internal ROM. Note time is paced by the one-cycle 'tick' enable.
//
// Parameters
//   NOTE_W      width of note_code (0 = rest, 1..15 = Voice pitch index)
//   DUR_W       width of the per-note duration field, in ticks
//
// Ports
//   clk         in   1       system clock
//   rst         in   1       synchronous, active-low reset
//   tick        in   1       one-cycle note-time enable
//   req         in   4       request pulses: [0] step [1] hit [2] win [3] lose
//   abort       in   1       stop the current effect immediately
//   busy        out  1       effect in progress
//   active_id   out  2       index of the playing effect (valid while busy)
//   note_valid  out  1       note_code is claiming the Voice path
//   note_code   out  NOTE_W  pitch index of the current note
//   done        out  1       one-cycle pulse on natural completion
// ----------------------------------------------------------------------------
module sfx_scheduler #(
    parameter int NOTE_W = 5,
    parameter int DUR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [3:0]        req,
    input  logic              abort,
    output logic              busy,
    output logic [1:0]        active_id,
    output logic              note_valid,
    output logic [NOTE_W-1:0] note_code,
    output logic              done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [1:0] ID_STEP = 2'd0;
    localparam logic [1:0] ID_HIT  = 2'd1;
    localparam logic [1:0] ID_WIN  = 2'd2;
    localparam logic [1:0] ID_LOSE = 2'd3;

    state_t            state;
    logic [1:0]        idx;
    logic [DUR_W-1:0]  dur;

    logic              req_any;
    logic [1:0]        winner;
    logic              accept;
    logic              last_note;
    logic              dur_expiring;

    // Index of the final note of each effect.
    function automatic logic [1:0] last_idx(input logic [1:0] id);
        logic [1:0] r;
        case (id)
            ID_STEP: r = 2'd0;
            ID_HIT:  r = 2'd2;
            ID_WIN:  r = 2'd3;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Note ROM, addressed by {effect, note index}.
    function automatic logic [NOTE_W-1:0] rom_note(input logic [1:0] id,
                                                   input logic [1:0] i);
        logic [NOTE_W-1:0] r;
        case ({id, i})
            {ID_STEP, 2'd0}: r = NOTE_W'(3);
            {ID_HIT,  2'd0}: r = NOTE_W'(12);
            {ID_HIT,  2'd1}: r = NOTE_W'(8);
            {ID_HIT,  2'd2}: r = NOTE_W'(4);
            {ID_WIN,  2'd0}: r = NOTE_W'(1);
            {ID_WIN,  2'd1}: r = NOTE_W'(3);
            {ID_WIN,  2'd2}: r = NOTE_W'(5);
            {ID_WIN,  2'd3}: r = NOTE_W'(8);
            {ID_LOSE, 2'd0}: r = NOTE_W'(8);
            {ID_LOSE, 2'd1}: r = NOTE_W'(6);
            {ID_LOSE, 2'd2}: r = NOTE_W'(4);
            {ID_LOSE, 2'd3}: r = NOTE_W'(1);
            default:         r = '0;
        endcase
        return r;
    endfunction

    // Duration ROM, same addressing. Zero is never stored, so an unused
    // address returning 1 keeps the counter well defined.
    function automatic logic [DUR_W-1:0] rom_dur(input logic [1:0] id,
                                                 input logic [1:0] i);
        logic [DUR_W-1:0] r;
        case ({id, i})
            {ID_STEP, 2'd0}: r = DUR_W'(1);
            {ID_HIT,  2'd0}: r = DUR_W'(1);
            {ID_HIT,  2'd1}: r = DUR_W'(1);
            {ID_HIT,  2'd2}: r = DUR_W'(2);
            {ID_WIN,  2'd0}: r = DUR_W'(2);
            {ID_WIN,  2'd1}: r = DUR_W'(2);
            {ID_WIN,  2'd2}: r = DUR_W'(2);
            {ID_WIN,  2'd3}: r = DUR_W'(4);
            {ID_LOSE, 2'd0}: r = DUR_W'(2);
            {ID_LOSE, 2'd1}: r = DUR_W'(2);
            {ID_LOSE, 2'd2}: r = DUR_W'(2);
            {ID_LOSE, 2'd3}: r = DUR_W'(6);
            default:         r = DUR_W'(1);
        endcase
        return r;
    endfunction

    // Fixed priority: the higher request index wins.
    always_comb begin
        req_any = |req;
        winner  = ID_STEP;
        if (req[3])
            winner = ID_LOSE;
        else if (req[2])
            winner = ID_WIN;
        else if (req[1])
            winner = ID_HIT;
    end

    // A request starts an effect from IDLE, or preempts only a strictly
    // lower-priority effect; equal or lower priority requests are dropped.
    always_comb begin
        accept       = req_any && ((state == IDLE) || (winner > active_id));
        last_note    = (idx == last_idx(active_id));
        dur_expiring = (dur == DUR_W'(1));
    end

    // Sequencer. Precedence per edge: reset, abort, accepted request, tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            active_id  <= 2'd0;
            note_valid <= 1'b0;
            note_code  <= '0;
            done       <= 1'b0;
            idx        <= 2'd0;
            dur        <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                active_id  <= 2'd0;
                note_valid <= 1'b0;
                note_code  <= '0;
                idx        <= 2'd0;
                dur        <= '0;
            end else if (accept) begin
                // The tick on this edge is deliberately ignored so the first
                // note lasts its full duration counted from the next tick.
                state      <= PLAY;
                busy       <= 1'b1;
                active_id  <= winner;
                note_valid <= 1'b1;
                note_code  <= rom_note(winner, 2'd0);
                idx        <= 2'd0;
                dur        <= rom_dur(winner, 2'd0);
            end else if ((state == PLAY) && tick) begin
                if (!dur_expiring) begin
                    dur <= dur - DUR_W'(1);
                end else if (!last_note) begin
                    idx       <= idx + 2'd1;
                    note_code <= rom_note(active_id, idx + 2'd1);
                    dur       <= rom_dur(active_id, idx + 2'd1);
                end else begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    active_id  <= 2'd0;
                    note_valid <= 1'b0;
                    note_code  <= '0;
                    idx        <= 2'd0;
                    dur        <= '0;
                    done       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sfx_scheduler
//
// Self-checking bench for sfx_scheduler. Every cycle is driven by
// applyStimulus, which pushes the hand-derived expected outputs to a
// scoreboard queue; after the edge the entry is popped and compared.
// ----------------------------------------------------------------------------
module tb_sfx_scheduler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] req;
    logic       abort;
    logic       busy;
    logic [1:0] active_id;
    logic       note_valid;
    logic [4:0] note_code;
    logic       done;

    typedef struct packed {
        logic       busy;
        logic [1:0] id;
        logic       valid;
        logic [4:0] code;
        logic       done;
    } exp_t;

    exp_t scoreboard[$];
    int   checks;
    int   passed;

    sfx_scheduler #(
        .NOTE_W(5),
        .DUR_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req),
        .abort     (abort),
        .busy      (busy),
        .active_id (active_id),
        .note_valid(note_valid),
        .note_code (note_code),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got,
                               input logic [7:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Drive one cycle of inputs, record the expected post-edge outputs and
    // compare them once the edge has happened.
    task automatic applyStimulus(input string tag, input logic rst_n,
                                 input logic [3:0] rq, input logic tk,
                                 input logic ab, input logic eb,
                                 input logic [1:0] eid, input logic ev,
                                 input logic [4:0] ec, input logic ed);
        exp_t e;
        exp_t want;
        @(negedge clk);
        rst   = rst_n;
        req   = rq;
        tick  = tk;
        abort = ab;
        e.busy  = eb;
        e.id    = eid;
        e.valid = ev;
        e.code  = ec;
        e.done  = ed;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        want = scoreboard.pop_front();
        checkOutput({tag, ".busy"},  8'(busy),       8'(want.busy));
        checkOutput({tag, ".valid"}, 8'(note_valid), 8'(want.valid));
        checkOutput({tag, ".code"},  8'(note_code),  8'(want.code));
        checkOutput({tag, ".done"},  8'(done),       8'(want.done));
        if (want.busy)
            checkOutput({tag, ".id"}, 8'(active_id), 8'(want.id));
    endtask

    int win_codes[9]   = '{1, 3, 3, 5, 5, 8, 8, 8, 8};
    int lose_codes[11] = '{8, 6, 6, 4, 4, 1, 1, 1, 1, 1, 1};

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b0;
        req    = 4'b0000;
        tick   = 1'b0;
        abort  = 1'b0;

        // Power-on reset.
        applyStimulus("reset0", 0, 4'b0000, 0, 0, 0, 0, 0, 5'd0, 0);
        applyStimulus("reset1", 0, 4'b0000, 0, 0, 0, 0, 0, 5'd0, 0);
        applyStimulus("idle",   1, 4'b0000, 0, 0, 0, 0, 0, 5'd0, 0);

        // Step: one note of one tick.
        applyStimulus("step_start", 1, 4'b0001, 0, 0, 1, 0, 1, 5'd3, 0);
        applyStimulus("step_done",  1, 4'b0000, 1, 0, 0, 0, 0, 5'd0, 1);
        applyStimulus("step_after", 1, 4'b0000, 0, 0, 0, 0, 0, 5'd0, 0);

        // Hit full run, with an idle cycle to show notes hold without tick.
        applyStimulus("hit_start", 1, 4'b0010, 0, 0, 1, 1, 1, 5'd12, 0);
        applyStimulus("hit_t1",    1, 4'b0000, 1, 0, 1, 1, 1, 5'd8,  0);
        applyStimulus("hit_hold",  1, 4'b0000, 0, 0, 1, 1, 1, 5'd8,  0);
        applyStimulus("hit_t2",    1, 4'b0000, 1, 0, 1, 1, 1, 5'd4,  0);
        applyStimulus("hit_t3",    1, 4'b0000, 1, 0, 1, 1, 1, 5'd4,  0);
        applyStimulus("hit_done",  1, 4'b0000, 1, 0, 0, 0, 0, 5'd0,  1);
        applyStimulus("hit_after", 1, 4'b0000, 0, 0, 0, 0, 0, 5'd0,  0);

        // Preempt hit at note 8 with lose; hit never signals done.
        applyStimulus("pre_hit",   1, 4'b0010, 0, 0, 1, 1, 1, 5'd12, 0);
        applyStimulus("pre_hit8",  1, 4'b0000, 1, 0, 1, 1, 1, 5'd8,  0);
        applyStimulus("pre_lose",  1, 4'b1000, 0, 0, 1, 3, 1, 5'd8,  0);
        applyStimulus("pre_l_t1",  1, 4'b0000, 1, 0, 1, 3, 1, 5'd8,  0);
        applyStimulus("pre_l_t2",  1, 4'b0000, 1, 0, 1, 3, 1, 5'd6,  0);
        applyStimulus("pre_abort", 1, 4'b0000, 0, 1, 0, 0, 0, 5'd0,  0);

        // Drop lower and equal priority requests while win plays.
        applyStimulus("drop_win",  1, 4'b0100, 0, 0, 1, 2, 1, 5'd1, 0);
        applyStimulus("drop_low",  1, 4'b0011, 0, 0, 1, 2, 1, 5'd1, 0);
        applyStimulus("drop_t1",   1, 4'b0000, 1, 0, 1, 2, 1, 5'd1, 0);
        applyStimulus("drop_t2",   1, 4'b0000, 1, 0, 1, 2, 1, 5'd3, 0);
        applyStimulus("drop_same", 1, 4'b0100, 1, 0, 1, 2, 1, 5'd3, 0);
        applyStimulus("drop_t4",   1, 4'b0000, 1, 0, 1, 2, 1, 5'd5, 0);

        // abort beats req and tick in the same cycle.
        applyStimulus("coll_abort", 1, 4'b1000, 1, 1, 0, 0, 0, 5'd0, 0);
        applyStimulus("abort_idle", 1, 4'b0000, 0, 1, 0, 0, 0, 5'd0, 0);

        // Multiple bits in IDLE: lose wins.
        applyStimulus("multi_lose", 1, 4'b1010, 0, 0, 1, 3, 1, 5'd8, 0);
        applyStimulus("multi_abrt", 1, 4'b0000, 0, 1, 0, 0, 0, 5'd0, 0);

        // req+tick in IDLE: first note keeps its full two-tick duration.
        applyStimulus("rt_start", 1, 4'b0100, 1, 0, 1, 2, 1, 5'd1, 0);
        applyStimulus("rt_t1",    1, 4'b0000, 1, 0, 1, 2, 1, 5'd1, 0);
        applyStimulus("rt_t2",    1, 4'b0000, 1, 0, 1, 2, 1, 5'd3, 0);

        // Reset held three cycles mid-win, ticks still arriving.
        applyStimulus("mid_rst0", 0, 4'b0000, 1, 0, 0, 0, 0, 5'd0, 0);
        applyStimulus("mid_rst1", 0, 4'b0001, 1, 0, 0, 0, 0, 5'd0, 0);
        applyStimulus("mid_rst2", 0, 4'b0000, 1, 0, 0, 0, 0, 5'd0, 0);
        applyStimulus("mid_rel",  1, 4'b0000, 1, 0, 0, 0, 0, 5'd0, 0);

        // Win full run to completion.
        applyStimulus("win_start", 1, 4'b0100, 0, 0, 1, 2, 1, 5'd1, 0);
        for (int i = 0; i < 9; i++)
            applyStimulus("win_run", 1, 4'b0000, 1, 0, 1, 2, 1,
                          5'(win_codes[i]), 0);
        applyStimulus("win_done", 1, 4'b0000, 1, 0, 0, 0, 0, 5'd0, 1);

        // Lose full run, including the six-tick final note.
        applyStimulus("lose_start", 1, 4'b1000, 0, 0, 1, 3, 1, 5'd8, 0);
        for (int i = 0; i < 11; i++)
            applyStimulus("lose_run", 1, 4'b0000, 1, 0, 1, 3, 1,
                          5'(lose_codes[i]), 0);
        applyStimulus("lose_done",  1, 4'b0000, 1, 0, 0, 0, 0, 5'd0, 1);
        applyStimulus("lose_after", 1, 4'b0000, 1, 0, 0, 0, 0, 5'd0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
